// File: rtl/modulus_lut_loadable.sv
// Runtime-loadable reduction table holding DEPTH entries of MODULUS_WIDTH bits.
// The host streams entries in LOAD_WIDTH chunks (least-significant chunk first);
// once the whole table is present, lookups issue one per cycle with a fixed
// READ_LATENCY of 1 or 2 cycles.
module modulus_lut_loadable #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int IDX_BITS      = 5,
  parameter int LOAD_WIDTH    = 32,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [LOAD_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     table_valid,
  input  logic                     lut_req,
  input  logic [IDX_BITS-1:0]      lut_idx,
  output logic [MODULUS_WIDTH-1:0] lut_out,
  output logic                     lut_out_valid,
  output logic                     lut_err
);
  localparam int DEPTH  = 2 ** IDX_BITS;
  localparam int CHUNKS = MODULUS_WIDTH / LOAD_WIDTH;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if ((MODULUS_WIDTH % LOAD_WIDTH) != 0) begin : g_bad_load_width
    $error("MODULUS_WIDTH must be a multiple of LOAD_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            chunk_cnt_q, chunk_cnt_d;
  logic [IDX_BITS-1:0]      entry_ptr_q, entry_ptr_d;
  logic [MODULUS_WIDTH-1:0] asm_q, asm_d;
  logic [MODULUS_WIDTH-1:0] mem [DEPTH];

  logic                     beat_acc;
  logic                     last_chunk;
  logic                     wr_en;
  logic                     rd_fire;
  logic                     fin_vld;
  logic [MODULUS_WIDTH-1:0] fin_data;
  logic [MODULUS_WIDTH-1:0] lut_out_q;
  logic                     lut_out_valid_q;
  logic                     lut_err_q;

  // A restart pulse takes priority, so a beat arriving with it is discarded.
  assign beat_acc   = (state_q == LOADING) && load_valid && !load_start;
  assign last_chunk = (chunk_cnt_q == CW'(CHUNKS - 1));
  assign wr_en      = beat_acc && last_chunk;

  assign load_ready  = (state_q == LOADING);
  assign table_valid = (state_q == READY);

  // Loader FSM next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    entry_ptr_d = entry_ptr_q;
    if (load_start) begin
      state_d     = LOADING;
      chunk_cnt_d = '0;
      entry_ptr_d = '0;
    end else if (beat_acc) begin
      if (last_chunk) begin
        chunk_cnt_d = '0;
        entry_ptr_d = entry_ptr_q + 1'b1;
        if (entry_ptr_q == IDX_BITS'(DEPTH - 1)) begin
          state_d = READY;
        end
      end else begin
        chunk_cnt_d = chunk_cnt_q + 1'b1;
      end
    end
  end

  // Merge the incoming chunk into the partially assembled entry.
  always_comb begin
    asm_d = asm_q;
    asm_d[int'(chunk_cnt_q) * LOAD_WIDTH +: LOAD_WIDTH] = load_data;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      chunk_cnt_q <= '0;
      entry_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      entry_ptr_q <= entry_ptr_d;
    end
  end

  // Assembly register and table RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      asm_q <= asm_d;
    end
    if (wr_en) begin
      mem[entry_ptr_q] <= asm_d;
    end
  end

  // Reads only go ahead against a complete table.
  assign rd_fire = lut_req && table_valid;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [MODULUS_WIDTH-1:0] rd_data_p0_q;
    logic                     vld_p0_q;

    // Stage p0: registered RAM read.
    always_ff @(posedge clk) begin
      if (rd_fire) begin
        rd_data_p0_q <= mem[lut_idx];
      end
    end

    // Stage p0 valid travels with the read data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p0_q <= 1'b0;
      end else begin
        vld_p0_q <= rd_fire;
      end
    end

    assign fin_vld  = vld_p0_q;
    assign fin_data = rd_data_p0_q;
  end else begin : g_lat1
    assign fin_vld  = rd_fire;
    assign fin_data = mem[lut_idx];
  end

  // Output stage: lut_out holds its value between valid reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_out_q       <= '0;
      lut_out_valid_q <= 1'b0;
      lut_err_q       <= 1'b0;
    end else begin
      lut_out_valid_q <= fin_vld;
      lut_err_q       <= lut_req && !table_valid;
      if (fin_vld) begin
        lut_out_q <= fin_data;
      end
    end
  end

  assign lut_out       = lut_out_q;
  assign lut_out_valid = lut_out_valid_q;
  assign lut_err       = lut_err_q;

endmodule

// File: tb/tb_modulus_lut_loadable.sv
// Bench for modulus_lut_loadable: one instance per legal read latency, both fed
// the same stimulus and compared against a table-level reference model.
module tb_modulus_lut_loadable;
  localparam int MW     = 1024;
  localparam int IB     = 5;
  localparam int LW     = 32;
  localparam int DEPTH  = 32;
  localparam int CHUNKS = MW / LW;
  localparam int TOTAL  = DEPTH * CHUNKS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          load_valid;
  logic [LW-1:0] load_data;
  logic          lut_req;
  logic [IB-1:0] lut_idx;

  logic          load_ready1, table_valid1, lut_out_valid1, lut_err1;
  logic [MW-1:0] lut_out1;
  logic          load_ready2, table_valid2, lut_out_valid2, lut_err2;
  logic [MW-1:0] lut_out2;

  logic [MW-1:0] model_tab [DEPTH];
  logic [MW-1:0] stage_tab [DEPTH];
  bit            model_valid;
  logic [MW-1:0] exp_out1, exp_out2;
  int            req_idx [64];
  int            n_checks, n_fail;

  modulus_lut_loadable #(.MODULUS_WIDTH(MW), .IDX_BITS(IB), .LOAD_WIDTH(LW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready1), .table_valid(table_valid1),
    .lut_req(lut_req), .lut_idx(lut_idx), .lut_out(lut_out1),
    .lut_out_valid(lut_out_valid1), .lut_err(lut_err1));

  modulus_lut_loadable #(.MODULUS_WIDTH(MW), .IDX_BITS(IB), .LOAD_WIDTH(LW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready2), .table_valid(table_valid2),
    .lut_req(lut_req), .lut_idx(lut_idx), .lut_out(lut_out2),
    .lut_out_valid(lut_out_valid2), .lut_err(lut_err2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] chunk_val(input int pat, input int k, input int c);
    case (pat)
      0:       return 32'hA000_0000 + LW'(k);
      1:       return 32'h5000_0000 + LW'(k << 8) + LW'(c);
      2:       return LW'($urandom);
      default: return 32'hC0DE_0000 ^ LW'(k << 12) ^ LW'(c);
    endcase
  endfunction

  function automatic int diff_chunk(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < CHUNKS; i++) begin
      if (a[i*LW +: LW] !== b[i*LW +: LW]) return i;
    end
    return 0;
  endfunction

  // Streams nbeats beats after a start pulse; a full load replaces the model table.
  task automatic do_load(input int pat, input int bubble_pct, input int nbeats, input bit junk_beat);
    int k, c, g;
    logic [LW-1:0] d;
    load_start = 1'b1;
    load_valid = junk_beat;
    load_data  = 32'hDEAD_BEEF;
    tick();
    load_start  = 1'b0;
    load_valid  = 1'b0;
    model_valid = 1'b0;
    n_checks += 2;
    if ({load_ready1, load_ready2} !== 2'b11) begin
      n_fail++; $display("FAIL load_ready_after_start got=%b%b exp=11", load_ready1, load_ready2);
    end
    if ({table_valid1, table_valid2} !== 2'b00) begin
      n_fail++; $display("FAIL table_valid_after_start got=%b%b exp=00", table_valid1, table_valid2);
    end
    for (int b = 0; b < nbeats; b++) begin
      k = b / CHUNKS;
      c = b % CHUNKS;
      g = 0;
      while (g < 8 && $urandom_range(99) < bubble_pct) begin
        load_valid = 1'b0;
        load_data  = LW'($urandom);
        tick();
        g++;
      end
      d = chunk_val(pat, k, c);
      stage_tab[k][c*LW +: LW] = d;
      load_valid = 1'b1;
      load_data  = d;
      if (b == TOTAL - 1) begin
        n_checks++;
        if ({table_valid1, table_valid2} !== 2'b00) begin
          n_fail++; $display("FAIL table_valid_early got=%b%b exp=00", table_valid1, table_valid2);
        end
      end
      tick();
    end
    load_valid = 1'b0;
    if (nbeats == TOTAL) begin
      for (int i = 0; i < DEPTH; i++) model_tab[i] = stage_tab[i];
      model_valid = 1'b1;
      n_checks += 2;
      if ({table_valid1, table_valid2} !== 2'b11) begin
        n_fail++; $display("FAIL table_valid_rise got=%b%b exp=11", table_valid1, table_valid2);
      end
      if ({load_ready1, load_ready2} !== 2'b00) begin
        n_fail++; $display("FAIL load_ready_when_ready got=%b%b exp=00", load_ready1, load_ready2);
      end
    end else begin
      n_checks++;
      if ({table_valid1, load_ready1, table_valid2, load_ready2} !== 4'b0101) begin
        n_fail++; $display("FAIL partial_load_flags got=%b%b%b%b exp=0101",
                           table_valid1, load_ready1, table_valid2, load_ready2);
      end
    end
  endtask

  // Issues req_idx[0..n-1] on consecutive cycles and checks both latencies cycle by cycle.
  task automatic run_lookups(input int n);
    bit e_v1, e_v2, e_err;
    int ci;
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) begin
        lut_req = 1'b1;
        lut_idx = IB'(req_idx[t]);
      end else begin
        lut_req = 1'b0;
        lut_idx = IB'($urandom);
      end
      tick();
      e_err = (t < n) && !model_valid;
      e_v1  = (t < n) && model_valid;
      e_v2  = (t >= 1) && (t - 1 < n) && model_valid;
      if (e_v1) exp_out1 = model_tab[req_idx[t]];
      if (e_v2) exp_out2 = model_tab[req_idx[t-1]];
      n_checks += 5;
      if ({table_valid1, table_valid2} !== {model_valid, model_valid}) begin
        n_fail++; $display("FAIL table_valid t=%0d got=%b%b exp=%b", t, table_valid1, table_valid2, model_valid);
      end
      if ({lut_err1, lut_err2} !== {e_err, e_err}) begin
        n_fail++; $display("FAIL lut_err t=%0d got=%b%b exp=%b", t, lut_err1, lut_err2, e_err);
      end
      if ({lut_out_valid1, lut_out_valid2} !== {e_v1, e_v2}) begin
        n_fail++; $display("FAIL lut_out_valid t=%0d got=%b%b exp=%b%b", t, lut_out_valid1, lut_out_valid2, e_v1, e_v2);
      end
      if (lut_out1 !== exp_out1) begin
        ci = diff_chunk(lut_out1, exp_out1);
        n_fail++; $display("FAIL lut_out_lat1 t=%0d chunk=%0d got=%h exp=%h", t, ci,
                           lut_out1[ci*LW +: LW], exp_out1[ci*LW +: LW]);
      end
      if (lut_out2 !== exp_out2) begin
        ci = diff_chunk(lut_out2, exp_out2);
        n_fail++; $display("FAIL lut_out_lat2 t=%0d chunk=%0d got=%h exp=%h", t, ci,
                           lut_out2[ci*LW +: LW], exp_out2[ci*LW +: LW]);
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) req_idx[i] = DEPTH - 1 - i;
    run_lookups(DEPTH);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    model_valid = 1'b0;
    exp_out1 = '0;
    exp_out2 = '0;
    n_checks += 3;
    if ({load_ready1, table_valid1, lut_out_valid1, lut_err1,
         load_ready2, table_valid2, lut_out_valid2, lut_err2} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags got=%b%b%b%b_%b%b%b%b exp=0000_0000",
                         load_ready1, table_valid1, lut_out_valid1, lut_err1,
                         load_ready2, table_valid2, lut_out_valid2, lut_err2);
    end
    if (lut_out1 !== '0) begin
      n_fail++; $display("FAIL reset_lut_out1 got_lo=%h exp=0", lut_out1[63:0]);
    end
    if (lut_out2 !== '0) begin
      n_fail++; $display("FAIL reset_lut_out2 got_lo=%h exp=0", lut_out2[63:0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_err_before_load();
    req_idx[0] = 3;
    run_lookups(1);
  endtask

  task automatic test_gapless_load();
    do_load(0, 0, TOTAL, 1'b0);
    req_idx[0] = 7;
    run_lookups(1);
    read_all();
  endtask

  task automatic test_back_to_back();
    req_idx[0] = 0; req_idx[1] = 31; req_idx[2] = 5; req_idx[3] = 5;
    run_lookups(4);
    for (int i = 0; i < 16; i++) req_idx[i] = $urandom_range(DEPTH - 1);
    run_lookups(16);
  endtask

  task automatic test_bubble_load();
    do_load(1, 50, TOTAL, 1'b0);
    read_all();
  endtask

  task automatic test_restart_load();
    do_load(3, 0, 500, 1'b0);
    req_idx[0] = 9;
    run_lookups(1);
    do_load(2, 0, TOTAL, 1'b1);
    read_all();
  endtask

  task automatic test_reset_mid_load();
    do_load(3, 0, 300, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_valid = 1'b0;
    exp_out1 = '0;
    exp_out2 = '0;
    n_checks++;
    if ({table_valid1, load_ready1, table_valid2, load_ready2} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_load_flags got=%b%b%b%b exp=0000",
                         table_valid1, load_ready1, table_valid2, load_ready2);
    end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = LW'($urandom);
      tick();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) req_idx[i] = $urandom_range(DEPTH - 1);
    run_lookups(4);
    do_load(0, 50, TOTAL, 1'b0);
    read_all();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    lut_req    = 1'b0;
    lut_idx    = '0;
    test_reset();
    test_err_before_load();
    test_gapless_load();
    test_back_to_back();
    test_bubble_load();
    test_restart_load();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
